// File: rtl/pc_redirect_arbiter.sv
// Front-end redirect arbiter: picks trap/decode1/decode2 redirects, holds one
// until the PC stage handshakes it, and sequences boot and post-trap drain.
module pc_redirect_arbiter #(
  parameter int unsigned PC_W         = 64,
  parameter logic [PC_W-1:0] RESET_PC = 64'h0000000080000000,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trap_ena,
  input  logic [PC_W-1:0]  trap_pc,
  input  logic             decode1_ena,
  input  logic [PC_W-1:0]  decode1_pc,
  input  logic             decode2_ena,
  input  logic [PC_W-1:0]  decode2_pc,
  input  logic             fetch_ready,
  output logic             redir_valid,
  output logic [PC_W-1:0]  redir_pc,
  output logic [1:0]       redir_src,
  output logic             flush_front,
  output logic             drain_busy,
  output logic [CNT_W-1:0] redir_cnt
);

  localparam int unsigned DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [1:0] {BOOT, IDLE, PEND, DRAIN} state_e;
  typedef enum logic [1:0] {SRC_BOOT, SRC_DEC1, SRC_DEC2, SRC_TRAP} src_e;

  state_e           state_q, state_d;
  src_e             redir_src_q, redir_src_d;
  logic             redir_valid_q, redir_valid_d;
  logic [PC_W-1:0]  redir_pc_q, redir_pc_d;
  logic             flush_front_q, flush_front_d;
  logic             drain_busy_q, drain_busy_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;

  logic             any_req;
  logic             handshake;
  src_e             win_src;
  logic [PC_W-1:0]  win_pc;

  always_comb begin
    any_req = trap_ena | decode1_ena | decode2_ena;
    win_src = SRC_DEC2;
    win_pc  = decode2_pc;
    if (trap_ena) begin
      win_src = SRC_TRAP;
      win_pc  = trap_pc;
    end else if (decode1_ena) begin
      win_src = SRC_DEC1;
      win_pc  = decode1_pc;
    end
  end

  assign handshake = redir_valid_q & fetch_ready;

  always_comb begin
    state_d       = state_q;
    redir_src_d   = redir_src_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    flush_front_d = 1'b0;
    redir_cnt_d   = redir_cnt_q;
    drain_cnt_d   = drain_cnt_q;

    unique case (state_q)
      BOOT: begin
        redir_valid_d = 1'b1;
        redir_pc_d    = RESET_PC;
        redir_src_d   = SRC_BOOT;
        state_d       = PEND;
      end
      IDLE: begin
        if (any_req) begin
          redir_valid_d = 1'b1;
          redir_pc_d    = {win_pc[PC_W-1:1], 1'b0};
          redir_src_d   = win_src;
          flush_front_d = 1'b1;
          state_d       = PEND;
        end
      end
      PEND: begin
        if (handshake) begin
          redir_cnt_d = redir_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          // A request in the handshake cycle takes over the slot and skips drain.
          if (any_req) begin
            redir_pc_d    = {win_pc[PC_W-1:1], 1'b0};
            redir_src_d   = win_src;
            flush_front_d = 1'b1;
          end else begin
            redir_valid_d = 1'b0;
            if (redir_src_q == SRC_TRAP && DRAIN_CYCLES > 0) begin
              state_d     = DRAIN;
              drain_cnt_d = DW'(DRAIN_CYCLES);
            end else begin
              state_d = IDLE;
            end
          end
        end else if (trap_ena && redir_src_q != SRC_TRAP) begin
          redir_pc_d    = {trap_pc[PC_W-1:1], 1'b0};
          redir_src_d   = SRC_TRAP;
          flush_front_d = 1'b1;
        end
      end
      DRAIN: begin
        if (trap_ena) begin
          redir_valid_d = 1'b1;
          redir_pc_d    = {trap_pc[PC_W-1:1], 1'b0};
          redir_src_d   = SRC_TRAP;
          flush_front_d = 1'b1;
          drain_cnt_d   = '0;
          state_d       = PEND;
        end else begin
          drain_cnt_d = drain_cnt_q - {{(DW-1){1'b0}}, 1'b1};
          if (drain_cnt_q <= {{(DW-1){1'b0}}, 1'b1}) begin
            drain_cnt_d = '0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = BOOT;
    endcase

    drain_busy_d = (state_d == DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      redir_src_q   <= SRC_BOOT;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      flush_front_q <= 1'b0;
      drain_busy_q  <= 1'b0;
      redir_cnt_q   <= '0;
      drain_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      redir_src_q   <= redir_src_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      flush_front_q <= flush_front_d;
      drain_busy_q  <= drain_busy_d;
      redir_cnt_q   <= redir_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
    end
  end

  assign redir_valid = redir_valid_q;
  assign redir_pc    = redir_pc_q;
  assign redir_src   = redir_src_q;
  assign flush_front = flush_front_q;
  assign drain_busy  = drain_busy_q;
  assign redir_cnt   = redir_cnt_q;

endmodule
